lfsr4_checker: RTL and testbench

Self-synchronising checker for the 4-bit LFSR word stream (polynomial next[3] = d[1]^d[0], next[2:0] = d[3:1], period 15, non-zero states only). It sits directly downstream of the 4-bit LFSR generator, or at the far end of a link carrying its output. It acquires lock on the incoming sequence, then freewheels a local reference LFSR. Against that reference it counts mismatched words and declares loss of lock. It is the test-side consumer used for link and BIST checks.

---
 rtl/lfsr4_checker.sv | 131 +++++++++++++
 tb/tb_lfsr4_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr4_checker.sv
// lfsr4_checker
//   Self-synchronising checker for the 4-bit LFSR word stream
//   (next[3] = d[1]^d[0], next[2:0] = d[3:1], period 15).
//   In SEARCH it reloads a reference from the received data and counts
//   consecutive correct predictions. After LOCK_CNT of them it enters LOCKED.
//   In LOCKED the reference freewheels. Mismatches are counted. LOSS_CNT
//   consecutive mismatches return the checker to SEARCH.
// Ports
//   Clk, Rst    : clock, synchronous active-high reset
//   In_valid    : In_data is sampled this cycle
//   In_data     : received LFSR word
//   Clr         : synchronous clear of Err_cnt / Word_cnt (lock state untouched)
//   Locked      : checker is LOCKED
//   Err_pulse   : one cycle per mismatched word sampled while LOCKED
//   Err_cnt     : saturating mismatch count while LOCKED
//   Word_cnt    : saturating count of words checked while LOCKED
module lfsr4_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_valid,
  input  logic [3:0]       In_data,
  input  logic             Clr,
  output logic             Locked,
  output logic             Err_pulse,
  output logic [ERR_W-1:0] Err_cnt,
  output logic [ERR_W-1:0] Word_cnt
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [4:0] LOCK_N = 5'(LOCK_CNT);
  localparam logic [4:0] LOSS_N = 5'(LOSS_CNT);

  function automatic logic [3:0] lfsr_next(input logic [3:0] d);
    return {d[1] ^ d[0], d[3:1]};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic             have_q, have_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             pulse_d;
  logic [ERR_W-1:0] err_d, word_d;
  logic [3:0]       pred;
  logic             match;

  assign pred  = lfsr_next(ref_q);
  assign match = (In_data == pred);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    have_d  = have_q;
    run_d   = run_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    err_d   = Err_cnt;
    word_d  = Word_cnt;
    if (In_valid) begin
      unique case (state_q)
        SEARCH: begin
          ref_d  = In_data;
          have_d = 1'b1;
          // All-zero word is excluded so the 0->0 lockup never locks.
          if (have_q && match && (In_data != 4'd0)) begin
            run_d = run_q + 4'd1;
            if (({1'b0, run_q} + 5'd1) == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          // Freewheel: a corrupt word never pulls the reference off course,
          // so one bad word costs exactly one error.
          ref_d = pred;
          if (Word_cnt != '1) word_d = Word_cnt + 1'b1;
          if (match) begin
            miss_d = 4'd0;
          end else begin
            pulse_d = 1'b1;
            if (Err_cnt != '1) err_d = Err_cnt + 1'b1;
            miss_d = miss_q + 4'd1;
            if (({1'b0, miss_q} + 5'd1) == LOSS_N) begin
              state_d = SEARCH;
              run_d   = 4'd0;
              have_d  = 1'b0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (Clr) begin
      err_d  = '0;
      word_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= SEARCH;
      ref_q     <= 4'd0;
      have_q    <= 1'b0;
      run_q     <= 4'd0;
      miss_q    <= 4'd0;
      Locked    <= 1'b0;
      Err_pulse <= 1'b0;
      Err_cnt   <= '0;
      Word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      have_q    <= have_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      Locked    <= (state_d == LOCKED);
      Err_pulse <= pulse_d;
      Err_cnt   <= err_d;
      Word_cnt  <= word_d;
    end
  end

endmodule

// File: tb/tb_lfsr4_checker.sv
module tb_lfsr4_checker;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         In_valid = 1'b0;
  logic [3:0]   In_data = 4'd0;
  logic         Clr = 1'b0;
  logic         Locked, Err_pulse;
  logic [W-1:0] Err_cnt, Word_cnt;

  lfsr4_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(W)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_data(In_data), .Clr(Clr),
    .Locked(Locked), .Err_pulse(Err_pulse), .Err_cnt(Err_cnt), .Word_cnt(Word_cnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers following the behavioural rules.
  int m_ref, m_have, m_run, m_miss, m_locked, m_pulse, m_err, m_word;

  function automatic int nxt(input int d);
    return (((d ^ (d >> 1)) & 1) << 3) | (d >> 1);
  endfunction

  task automatic model(input int v, input int d, input int c, input int r);
    if (r != 0) begin
      m_ref = 0; m_have = 0; m_run = 0; m_miss = 0;
      m_locked = 0; m_pulse = 0; m_err = 0; m_word = 0;
      return;
    end
    m_pulse = 0;
    if (v != 0) begin
      if (m_locked == 0) begin
        if (m_have != 0 && d == nxt(m_ref) && d != 0) begin
          m_run++;
          if (m_run == LOCK) begin m_locked = 1; m_miss = 0; end
        end else m_run = 0;
        m_ref = d; m_have = 1;
      end else begin
        if (m_word < MAXC) m_word++;
        if (d == nxt(m_ref)) m_miss = 0;
        else begin
          m_pulse = 1;
          if (m_err < MAXC) m_err++;
          m_miss++;
          if (m_miss == LOSS) begin m_locked = 0; m_run = 0; m_have = 0; end
        end
        m_ref = nxt(m_ref);
      end
    end
    if (c != 0) begin m_err = 0; m_word = 0; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int v, input int d, input int c, input int r, input string ph);
    In_valid = (v != 0); In_data = 4'(d); Clr = (c != 0); Rst = (r != 0);
    @(posedge Clk);
    model(v, d, c, r);
    #1;
    check({ph, ".locked"}, 32'(Locked), m_locked);
    check({ph, ".pulse"}, 32'(Err_pulse), m_pulse);
    check({ph, ".err"}, 32'(Err_cnt), m_err);
    check({ph, ".word"}, 32'(Word_cnt), m_word);
  endtask

  task automatic feed(input int d, input string ph);
    step(1, d, 0, 0, ph);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1, "rst");
    step(0, 0, 0, 0, "rst_idle");
  endtask

  task automatic lock_seq(input string ph);
    feed(9, ph); feed(12, ph); feed(6, ph); feed(11, ph); feed(5, ph);
  endtask

  initial begin
    int g, w, burst;
    int seq[6];
    m_ref = 0; m_have = 0; m_run = 0; m_miss = 0;
    m_locked = 0; m_pulse = 0; m_err = 0; m_word = 0;

    // Reset state
    do_reset();
    check("reset_locked", 32'(Locked), 0);
    check("reset_err", 32'(Err_cnt), 0);
    check("reset_word", 32'(Word_cnt), 0);

    // Lock acquisition
    feed(9, "acq"); feed(12, "acq"); check("acq_C", 32'(Locked), 0);
    feed(6, "acq"); check("acq_6", 32'(Locked), 0);
    feed(11, "acq"); check("acq_B", 32'(Locked), 0);
    feed(5, "acq"); check("acq_5", 32'(Locked), 1);
    check("acq_err", 32'(Err_cnt), 0);

    // Single corrupted word
    feed(2, "single"); check("single_pulse", 32'(Err_pulse), 1);
    feed(13, "single"); check("single_nopulse", 32'(Err_pulse), 0);
    feed(14, "single"); feed(15, "single");
    check("single_err", 32'(Err_cnt), 1);
    check("single_word", 32'(Word_cnt), 4);
    check("single_locked", 32'(Locked), 1);

    // Loss of lock, then zero lockup
    do_reset(); lock_seq("loss");
    feed(0, "loss"); feed(0, "loss"); check("loss_still", 32'(Locked), 1);
    feed(0, "loss");
    check("loss_fall", 32'(Locked), 0);
    check("loss_err", 32'(Err_cnt), 3);
    for (int i = 0; i < 5; i++) feed(0, "zero");
    check("zero_nolock", 32'(Locked), 0);

    // Valid gaps
    do_reset();
    seq = '{9, 12, 6, 11, 5, 10};
    for (int i = 0; i < 6; i++) begin
      feed(seq[i], "gap");
      if (i == 4) check("gap_lock", 32'(Locked), 1);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, "gap_idle");
    end
    check("gap_err", 32'(Err_cnt), 0);
    check("gap_word", 32'(Word_cnt), 1);

    // Saturation and Clr: two mismatches then a match keeps lock
    do_reset(); lock_seq("sat");
    g = nxt(5);
    for (int k = 0; k < 10; k++) begin
      feed(g ^ 4, "sat"); g = nxt(g);
      feed(g ^ 4, "sat"); g = nxt(g);
      feed(g, "sat");     g = nxt(g);
    end
    check("sat_err", 32'(Err_cnt), 15);
    check("sat_locked", 32'(Locked), 1);
    step(1, g ^ 4, 1, 0, "clr"); g = nxt(g);
    check("clr_err", 32'(Err_cnt), 0);
    check("clr_pulse", 32'(Err_pulse), 1);

    // Reset mid-operation with In_valid high, then re-lock
    step(1, g, 0, 1, "midrst");
    check("midrst_locked", 32'(Locked), 0);
    check("midrst_err", 32'(Err_cnt), 0);
    feed(7, "relock"); feed(3, "relock"); feed(1, "relock"); feed(8, "relock");
    check("relock_pre", 32'(Locked), 0);
    feed(4, "relock");
    check("relock", 32'(Locked), 1);

    // Randomized traffic: gaps, error bursts, clears, occasional reset
    g = $urandom_range(1, 15);
    burst = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1, g, 0, 1, "rnd_rst");
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, 0, ($urandom_range(0, 39) == 0) ? 1 : 0, 0, "rnd_idle");
      end else begin
        w = g; g = nxt(g);
        if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 4);
        if (burst > 0) begin w = w ^ $urandom_range(1, 15); burst--; end
        step(1, w, ($urandom_range(0, 39) == 0) ? 1 : 0, 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
